// File: rtl/combat_pkg.sv
// rtl/combat_pkg.sv - shared types and default constants for the enemy combat manager
package combat_pkg;

    typedef enum logic [1:0] {
        SLOT_DEAD     = 2'd0,
        SLOT_ALIVE    = 2'd1,
        SLOT_COOLDOWN = 2'd2
    } slot_state_e;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    localparam int DEF_N_ENEMY         = 4;
    localparam int DEF_FULL_HP         = 100;
    localparam int DEF_PLAYER_DMG      = 10;
    localparam int DEF_ENEMY_DMG       = 10;
    localparam int DEF_RESPAWN_BASE    = 40;
    localparam int DEF_RESPAWN_STAGGER = 40;
    localparam int DEF_HIT_COOLDOWN    = 8;
    localparam int DEF_PLAYER_HP       = 500;
    localparam int DEF_ATK_SHORT       = 16;
    localparam int DEF_ATK_LONG        = 80;
    localparam int DEF_ENEMY_W         = 26;
    localparam int DEF_ENEMY_H         = 26;

endpackage

// File: rtl/enemy_combat_mgr_if.sv
// rtl/enemy_combat_mgr_if.sv - per-frame player attack bus shared by all enemy slots
interface enemy_combat_mgr_if;
    logic       tick;
    logic       freeze;
    logic [8:0] atk_x;
    logic [8:0] atk_y;
    logic [1:0] dir;
    logic       atk_on;

    modport master (output tick, freeze, atk_x, atk_y, dir, atk_on);
    modport slave  (input  tick, freeze, atk_x, atk_y, dir, atk_on);
endinterface

// File: rtl/enemy_slot.sv
// rtl/enemy_slot.sv - one enemy: respawn/cooldown FSM, blood register and attack hit test
module enemy_slot
    import combat_pkg::*;
#(
    parameter int SLOT_IDX        = 0,
    parameter int FULL_HP         = DEF_FULL_HP,
    parameter int PLAYER_DMG      = DEF_PLAYER_DMG,
    parameter int RESPAWN_BASE    = DEF_RESPAWN_BASE,
    parameter int RESPAWN_STAGGER = DEF_RESPAWN_STAGGER,
    parameter int HIT_COOLDOWN    = DEF_HIT_COOLDOWN,
    parameter int ATK_SHORT       = DEF_ATK_SHORT,
    parameter int ATK_LONG        = DEF_ATK_LONG,
    parameter int ENEMY_W         = DEF_ENEMY_W,
    parameter int ENEMY_H         = DEF_ENEMY_H
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    enemy_combat_mgr_if.slave         bus,
    input  logic [8:0]                ex_i,
    input  logic [8:0]                ey_i,
    output logic                      alive_o,
    output logic [6:0]                blood_o,
    output logic                      kill_o
);

    localparam logic [1:0]  ST_DEAD     = SLOT_DEAD;
    localparam logic [1:0]  ST_ALIVE    = SLOT_ALIVE;
    localparam logic [1:0]  ST_COOLDOWN = SLOT_COOLDOWN;
    localparam logic [15:0] DELAY       = 16'(RESPAWN_BASE + SLOT_IDX * RESPAWN_STAGGER);
    localparam logic [15:0] CD          = 16'(HIT_COOLDOWN);
    localparam logic [6:0]  HP          = 7'(FULL_HP);
    localparam logic [6:0]  PD          = 7'(PLAYER_DMG);
    localparam logic [10:0] W           = 11'(ENEMY_W);
    localparam logic [10:0] H           = 11'(ENEMY_H);
    localparam logic [10:0] S           = 11'(ATK_SHORT);
    localparam logic [10:0] L           = 11'(ATK_LONG);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [6:0]  blood_q, blood_d;
    logic [10:0] ex, ey, ax, ay;
    logic        hit;
    logic        step;
    logic [6:0]  blood_hit;

    assign ex   = {2'b00, ex_i};
    assign ey   = {2'b00, ey_i};
    assign ax   = {2'b00, bus.atk_x};
    assign ay   = {2'b00, bus.atk_y};
    assign step = bus.tick & ~bus.freeze;

    // Inclusive attack box overlap; sides are moved instead of subtracting so nothing wraps
    always_comb begin
        hit = 1'b0;
        case (dir_e'(bus.dir))
            DIR_DOWN:  hit = (ex + W >= ax) && (ex <= ax + S) && (ey + H >= ay) && (ey <= ay + L);
            DIR_LEFT:  hit = (ex + W + L >= ax) && (ex <= ax) && (ey + H >= ay) && (ey <= ay + S);
            DIR_UP:    hit = (ex + W >= ax) && (ex <= ax + S) && (ey + H + L >= ay) && (ey <= ay);
            DIR_RIGHT: hit = (ex + W >= ax) && (ex <= ax + L) && (ey + H >= ay) && (ey <= ay + S);
            default:   hit = 1'b0;
        endcase
    end

    assign blood_hit = (blood_q > PD) ? (blood_q - PD) : 7'd0;
    assign kill_o    = step && (state_q == ST_ALIVE) && bus.atk_on && hit && (blood_hit == 7'd0);
    assign alive_o   = (state_q != ST_DEAD);
    assign blood_o   = blood_q;

    // Slot FSM next state: respawn wait, take hits, immunity countdown
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blood_d = blood_q;
        if (step) begin
            case (state_q)
                ST_DEAD: begin
                    if (cnt_q == DELAY) begin
                        cnt_d   = 16'd0;
                        blood_d = HP;
                        state_d = ST_ALIVE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_ALIVE: begin
                    if (bus.atk_on && hit) begin
                        blood_d = blood_hit;
                        if (blood_hit == 7'd0) begin
                            state_d = ST_DEAD;
                            cnt_d   = 16'd0;
                        end else begin
                            state_d = ST_COOLDOWN;
                            cnt_d   = CD;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    if (cnt_q <= 16'd1) begin
                        cnt_d   = 16'd0;
                        state_d = ST_ALIVE;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_d = ST_DEAD;
                    cnt_d   = 16'd0;
                end
            endcase
        end
    end

    // Slot state registers, cleared asynchronously to a fresh dead slot
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_DEAD;
            cnt_q   <= 16'd0;
            blood_q <= 7'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blood_q <= blood_d;
        end
    end

endmodule

// File: rtl/enemy_combat_mgr.sv
// rtl/enemy_combat_mgr.sv - enemy slots plus score, player blood and game-over tracking
module enemy_combat_mgr
    import combat_pkg::*;
#(
    parameter int N_ENEMY         = DEF_N_ENEMY,
    parameter int FULL_HP         = DEF_FULL_HP,
    parameter int PLAYER_DMG      = DEF_PLAYER_DMG,
    parameter int ENEMY_DMG       = DEF_ENEMY_DMG,
    parameter int RESPAWN_BASE    = DEF_RESPAWN_BASE,
    parameter int RESPAWN_STAGGER = DEF_RESPAWN_STAGGER,
    parameter int HIT_COOLDOWN    = DEF_HIT_COOLDOWN,
    parameter int PLAYER_HP       = DEF_PLAYER_HP,
    parameter int ATK_SHORT       = DEF_ATK_SHORT,
    parameter int ATK_LONG        = DEF_ATK_LONG,
    parameter int ENEMY_W         = DEF_ENEMY_W,
    parameter int ENEMY_H         = DEF_ENEMY_H
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   game_frame_clk_rising_edge,
    input  logic [8:0]             Attack_X,
    input  logic [8:0]             Attack_Y,
    input  logic [1:0]             Player_Direction,
    input  logic                   Attack_On,
    input  logic [9*N_ENEMY-1:0]   Enemy_X,
    input  logic [9*N_ENEMY-1:0]   Enemy_Y,
    input  logic [N_ENEMY-1:0]     Enemy_Attack_On,
    output logic [N_ENEMY-1:0]     Enemy_Alive,
    output logic [7*N_ENEMY-1:0]   Enemy_Blood,
    output logic [7:0]             Score,
    output logic [9:0]             Player_Blood,
    output logic                   Game_Over
);

    enemy_combat_mgr_if bus ();

    logic [N_ENEMY-1:0] kill;
    logic [7:0]         score_q, score_d;
    logic [9:0]         pb_q, pb_d;
    logic               go_q, go_d;
    logic [3:0]         kill_cnt;
    logic [3:0]         atk_cnt;
    logic [15:0]        dmg;
    logic [8:0]         score_sum;

    assign bus.tick   = game_frame_clk_rising_edge;
    assign bus.freeze = go_q;
    assign bus.atk_x  = Attack_X;
    assign bus.atk_y  = Attack_Y;
    assign bus.dir    = Player_Direction;
    assign bus.atk_on = Attack_On;

    genvar g;
    generate
        for (g = 0; g < N_ENEMY; g++) begin : g_slot
            enemy_slot #(
                .SLOT_IDX        (g),
                .FULL_HP         (FULL_HP),
                .PLAYER_DMG      (PLAYER_DMG),
                .RESPAWN_BASE    (RESPAWN_BASE),
                .RESPAWN_STAGGER (RESPAWN_STAGGER),
                .HIT_COOLDOWN    (HIT_COOLDOWN),
                .ATK_SHORT       (ATK_SHORT),
                .ATK_LONG        (ATK_LONG),
                .ENEMY_W         (ENEMY_W),
                .ENEMY_H         (ENEMY_H)
            ) u_slot (
                .clk_i   (Clk),
                .rst_i   (Reset),
                .bus     (bus.slave),
                .ex_i    (Enemy_X[9*g +: 9]),
                .ey_i    (Enemy_Y[9*g +: 9]),
                .alive_o (Enemy_Alive[g]),
                .blood_o (Enemy_Blood[7*g +: 7]),
                .kill_o  (kill[g])
            );
        end
    endgenerate

    // Count same-tick kills and live attackers; dead slots never hurt the player
    always_comb begin
        kill_cnt = 4'd0;
        atk_cnt  = 4'd0;
        for (int i = 0; i < N_ENEMY; i++) begin
            kill_cnt = kill_cnt + {3'b000, kill[i]};
            atk_cnt  = atk_cnt + {3'b000, Enemy_Attack_On[i] & Enemy_Alive[i]};
        end
    end

    assign dmg       = 16'(atk_cnt) * 16'(ENEMY_DMG);
    assign score_sum = {1'b0, score_q} + {5'b00000, kill_cnt};

    // Score and player blood update with saturation; game over latches and freezes everything
    always_comb begin
        score_d = score_q;
        pb_d    = pb_q;
        go_d    = go_q;
        if (game_frame_clk_rising_edge && !go_q) begin
            score_d = (score_sum > 9'd255) ? 8'd255 : score_sum[7:0];
            pb_d    = ({6'b000000, pb_q} > dmg) ? (pb_q - dmg[9:0]) : 10'd0;
            if (pb_d == 10'd0) begin
                go_d = 1'b1;
            end
        end
    end

    // Global score, player blood and game-over registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            score_q <= 8'd0;
            pb_q    <= 10'(PLAYER_HP);
            go_q    <= 1'b0;
        end else begin
            score_q <= score_d;
            pb_q    <= pb_d;
            go_q    <= go_d;
        end
    end

    assign Score        = score_q;
    assign Player_Blood = pb_q;
    assign Game_Over    = go_q;

endmodule

// File: tb/tb_enemy_combat_mgr.sv
// tb/tb_enemy_combat_mgr.sv - randomized and directed checks of enemy_combat_mgr against a frame-level model
module tb_enemy_combat_mgr;

    localparam int N = 4;

    logic           Clk = 1'b0;
    logic           Reset = 1'b0;
    logic [9*N-1:0] ex, ey;
    logic [N-1:0]   eatk;
    logic [N-1:0]   Enemy_Alive;
    logic [7*N-1:0] Enemy_Blood;
    logic [7:0]     Score;
    logic [9:0]     Player_Blood;
    logic           Game_Over;

    enemy_combat_mgr_if bus ();

    enemy_combat_mgr dut (
        .Clk                        (Clk),
        .Reset                      (Reset),
        .game_frame_clk_rising_edge (bus.tick),
        .Attack_X                   (bus.atk_x),
        .Attack_Y                   (bus.atk_y),
        .Player_Direction           (bus.dir),
        .Attack_On                  (bus.atk_on),
        .Enemy_X                    (ex),
        .Enemy_Y                    (ey),
        .Enemy_Attack_On            (eatk),
        .Enemy_Alive                (Enemy_Alive),
        .Enemy_Blood                (Enemy_Blood),
        .Score                      (Score),
        .Player_Blood               (Player_Blood),
        .Game_Over                  (Game_Over)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // frame-level model
    bit m_alive[N];
    int m_blood[N];
    int m_dead_ticks[N];
    int m_immune[N];
    int m_score;
    int m_pb;
    bit m_go;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d expected %0d at %0t", name, idx, act, exp, $time);
        end
    endtask

    function automatic int respawn_delay(input int i);
        return 40 + i * 40;
    endfunction

    function automatic bit m_hit(input int i);
        int x, y, ax, ay;
        x  = int'(ex[9*i +: 9]);
        y  = int'(ey[9*i +: 9]);
        ax = int'(bus.atk_x);
        ay = int'(bus.atk_y);
        case (bus.dir)
            2'd0:    return (x + 26 >= ax) && (x <= ax + 16) && (y + 26 >= ay) && (y <= ay + 80);
            2'd1:    return (x + 26 + 80 >= ax) && (x <= ax) && (y + 26 >= ay) && (y <= ay + 16);
            2'd2:    return (x + 26 >= ax) && (x <= ax + 16) && (y + 26 + 80 >= ay) && (y <= ay);
            default: return (x + 26 >= ax) && (x <= ax + 80) && (y + 26 >= ay) && (y <= ay + 16);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_alive[i] = 0; m_blood[i] = 0; m_dead_ticks[i] = 0; m_immune[i] = 0;
        end
        m_score = 0; m_pb = 500; m_go = 0;
    endtask

    task automatic model_tick();
        int attackers, kills;
        if (m_go) return;
        attackers = 0;
        kills = 0;
        for (int i = 0; i < N; i++) if (m_alive[i] && eatk[i]) attackers++;
        for (int i = 0; i < N; i++) begin
            if (!m_alive[i]) begin
                m_dead_ticks[i]++;
                if (m_dead_ticks[i] == respawn_delay(i) + 1) begin
                    m_alive[i] = 1; m_blood[i] = 100; m_immune[i] = 0; m_dead_ticks[i] = 0;
                end
            end else if (m_immune[i] > 0) begin
                m_immune[i]--;
            end else if (bus.atk_on && m_hit(i)) begin
                m_blood[i] = (m_blood[i] > 10) ? m_blood[i] - 10 : 0;
                if (m_blood[i] == 0) begin
                    m_alive[i] = 0; m_dead_ticks[i] = 0; kills++;
                end else begin
                    m_immune[i] = 8;
                end
            end
        end
        m_score = (m_score + kills > 255) ? 255 : m_score + kills;
        m_pb    = (m_pb > attackers * 10) ? m_pb - attackers * 10 : 0;
        if (m_pb == 0) m_go = 1;
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk("alive", i, 32'(Enemy_Alive[i]), 32'(m_alive[i]));
            chk("blood", i, 32'(Enemy_Blood[7*i +: 7]), 32'(m_blood[i]));
        end
        chk("score", 0, 32'(Score), 32'(m_score));
        chk("player_blood", 0, 32'(Player_Blood), 32'(m_pb));
        chk("game_over", 0, 32'(Game_Over), 32'(m_go));
    endtask

    task automatic step(input bit t);
        bus.tick = t;
        if (t) model_tick();
        @(posedge Clk);
        @(negedge Clk);
        check_all();
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b1);
    endtask

    // asserted away from any clock edge so outputs must change without one
    task automatic do_reset();
        bus.tick = 1'b0;
        Reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        check_all();
    endtask

    task automatic set_pos(input int i, input int x, input int y);
        ex[9*i +: 9] = 9'(x);
        ey[9*i +: 9] = 9'(y);
    endtask

    initial begin
        bus.tick = 0; bus.freeze = 0; bus.atk_x = 9'd90; bus.atk_y = 9'd110;
        bus.dir = 2'd3; bus.atk_on = 0; eatk = '0;
        for (int i = 0; i < N; i++) set_pos(i, 400, 400);
        @(negedge Clk);
        do_reset();
        chk("lit_reset_pb", 0, 32'(Player_Blood), 32'd500);

        // respawn timing and a double kill on one tick
        ticks(40);
        chk("lit_slot0_not_yet", 0, 32'(Enemy_Alive[0]), 32'd0);
        ticks(1);
        chk("lit_slot0_tick41", 0, 32'(Enemy_Alive[0]), 32'd1);
        ticks(39);
        chk("lit_slot1_not_yet", 1, 32'(Enemy_Alive[1]), 32'd0);
        ticks(1);
        chk("lit_slot1_tick81", 1, 32'(Enemy_Alive[1]), 32'd1);
        chk("lit_score0", 0, 32'(Score), 32'd0);
        set_pos(0, 100, 100);
        set_pos(1, 100, 100);
        bus.atk_on = 1;
        ticks(1);
        chk("lit_first_hit", 0, 32'(Enemy_Blood[6:0]), 32'd90);
        ticks(8);
        chk("lit_cooldown_hold", 0, 32'(Enemy_Blood[6:0]), 32'd90);
        ticks(1);
        chk("lit_second_hit", 0, 32'(Enemy_Blood[6:0]), 32'd80);
        ticks(71);
        chk("lit_blood10", 1, 32'(Enemy_Blood[13:7]), 32'd10);
        ticks(1);
        chk("lit_double_kill", 0, 32'(Score), 32'd2);
        chk("lit_both_dead", 0, 32'(Enemy_Alive[1:0]), 32'd0);

        // player death with saturation; dead slot's contact attack ignored
        bus.atk_on = 0;
        for (int i = 0; i < N; i++) set_pos(i, 400, 400);
        do_reset();
        eatk = 4'b1000;
        ticks(121);
        chk("lit_dead_attack_ignored", 0, 32'(Player_Blood), 32'd500);
        chk("lit_three_alive", 0, 32'(Enemy_Alive), 32'b0111);
        eatk = 4'b1111;
        ticks(16);
        chk("lit_pb20", 0, 32'(Player_Blood), 32'd20);
        ticks(1);
        chk("lit_pb0", 0, 32'(Player_Blood), 32'd0);
        chk("lit_game_over", 0, 32'(Game_Over), 32'd1);
        bus.atk_on = 1;
        for (int i = 0; i < N; i++) set_pos(i, 100, 100);
        ticks(20);
        chk("lit_frozen_alive", 0, 32'(Enemy_Alive), 32'b0111);
        chk("lit_frozen_blood", 0, 32'(Enemy_Blood[6:0]), 32'd100);

        // score saturation, then reset while slots are mid-cooldown
        eatk = '0;
        do_reset();
        bus.atk_on = 1;
        ticks(12000);
        chk("lit_score_sat", 0, 32'(Score), 32'd255);
        do_reset();
        chk("lit_reset_score", 0, 32'(Score), 32'd0);
        chk("lit_reset_alive", 0, 32'(Enemy_Alive), 32'd0);

        // randomized play
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            bus.atk_x  = 9'($urandom_range(70, 130));
            bus.atk_y  = 9'($urandom_range(70, 130));
            bus.dir    = 2'($urandom_range(0, 3));
            bus.atk_on = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) set_pos(i, $urandom_range(0, 511), $urandom_range(0, 511));
                else set_pos(i, $urandom_range(40, 200), $urandom_range(40, 200));
                eatk[i] = ($urandom_range(0, 31) == 0);
            end
            step($urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
